board_generator: RTL and testbench
==================================

# board_generator

Board setup controller for the 15x15 minesweeper core. On a start request it clears the board, places exactly MINES mines at pseudo-random positions from a 16-bit LFSR, and fills every non-mine cell with its neighbour-mine count. It drives the `data_minesweeper` board array consumed by the game-play FSM and the renderer, and it signals completion so the game can be released.

## Interface
- `MINES`, default 30: number of mines placed per board. Legal range is 1..200; elaboration fails outside this range.
- `SEED`, default 16'hACE1: LFSR reset value. It is also the substitute value whenever a zero seed is loaded.
- `clk_pix` in 1: pixel clock; the only clock.
- `sim_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to generate a new board. It is normally tied to the game restart pulse.
- `seed_load` in 1: when high in the same cycle as an accepted `start`, the LFSR loads `seed_in` instead of stepping.
- `seed_in` in 16: seed value used by `seed_load`.
- `data_minesweeper` out 4x225: board contents, row-major, index y*15+x. Each entry is 0..8 for a neighbour count or 10 for a mine.
- `busy` out 1: high while generation is in progress.
- `done` out 1: one-cycle pulse when a board is complete.
- `mines_placed` out 8: running count of mines written to the board.

## Operation
- LFSR is a Galois right-shift: next = {0, lfsr[15:1]} XOR (lfsr[0] ? 16'hB400 : 0).
  - It steps every cycle in every state, so user click timing adds entropy.
  - Exception: an accepted `start` with `seed_load`=1 loads `seed_in` instead of stepping. If `seed_in` is 0, it loads `SEED`.
- States are IDLE, CLEAR, PLACE, COUNT, DONE.
- IDLE: holds the board. `start` moves to CLEAR.
- CLEAR: all 225 entries are set to 0 in one cycle and `mines_placed` is set to 0. Next state is PLACE.
- PLACE: each cycle, candidate c = lfsr[7:0] (the current register value).
  - If c < 225 and entry c is not 10: write 10 to entry c and increment `mines_placed`.
  - Otherwise, reject the candidate; no write.
  - When `mines_placed` reaches MINES (the cycle the last write commits), go to COUNT with index k = 0.
- COUNT: one cell per cycle, k = 0..224, with x = k mod 15 and y = k div 15.
  - If entry k is 10, it is left unchanged.
  - Otherwise, entry k = number of the 8 neighbours equal to 10. Only in-bounds neighbours count: 0 <= x±1 <= 14 and 0 <= y±1 <= 14, with no wrap-around.
  - The x/y counters use 4-bit compares; the index uses an 8-bit counter.
  - After k = 224, go to DONE.
- DONE: `done` = 1 for exactly this cycle. Next state is IDLE.
- `start` in any non-IDLE state aborts and goes to CLEAR. The partial board is discarded and no `done` is produced for the aborted run.
  - `start` in the DONE cycle also goes to CLEAR; that DONE cycle's `done` pulse is still emitted.
- `seed_load` without `start` is ignored.

## Timing
- Reset values:
  - state IDLE; lfsr = `SEED`; every `data_minesweeper` entry 0.
  - `busy` 0; `done` 0; `mines_placed` 0.
- `start` sampled high at edge t:
  - CLEAR occupies cycle t+1; PLACE starts at t+2.
  - PLACE lasts at least MINES cycles; the exact length depends on rejected candidates.
  - COUNT lasts exactly 225 cycles, followed by one DONE cycle.
  - Minimum start-to-`done` latency is MINES+227 cycles.
- `busy` is registered. It is 1 in CLEAR, PLACE, COUNT and DONE, and 0 in IDLE. It falls in the cycle after `done`.
- Board entries are registered; a write is visible in the cycle after its decision. COUNT reads only mine markers, which are final after PLACE, so there is no read-after-write hazard.
- Reset asserted mid-operation returns immediately to the reset values, including clearing the board.
- `mines_placed` never exceeds MINES. The board holds exactly MINES entries equal to 10 whenever `done` pulses.

## Test plan
- Reset, then 10 idle cycles -> `busy`=0, `done`=0, `mines_placed`=0, all 225 entries 0.
- `start` with `seed_load`=1 and `seed_in`=16'h1234, MINES=30 -> exactly one `done` pulse, at least 257 cycles after `start`. The board holds exactly 30 entries equal to 10, and every other entry matches a bench neighbour-count model, including corners 0, 14, 210 and 224 and all edge cells.
- Same seed run twice back-to-back -> bit-identical boards and identical start-to-`done` latency.
- `seed_in`=0 with `seed_load` -> board identical to a run seeded with 16'hACE1.
- `start` re-asserted at cycle 100 of COUNT -> no `done` for the first run. CLEAR follows on the next cycle and exactly one `done` follows the second run.
- `sim_rst_n` pulsed low during PLACE -> all outputs return to reset values asynchronously and the block stays IDLE until the next `start`.

Source files
------------

// File: rtl/board_generator_if.sv
// Control and board bus between the minesweeper game logic (master) and the
// board generator (slave). Clock and reset stay as plain ports on the modules.
interface board_generator_if;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [3:0]  data_minesweeper [0:224];
    logic        busy;
    logic        done;
    logic [7:0]  mines_placed;

    modport master (
        output start,
        output seed_load,
        output seed_in,
        input  data_minesweeper,
        input  busy,
        input  done,
        input  mines_placed
    );

    modport slave (
        input  start,
        input  seed_load,
        input  seed_in,
        output data_minesweeper,
        output busy,
        output done,
        output mines_placed
    );
endinterface

// File: rtl/board_generator.sv
// Board setup controller for the 15x15 minesweeper core: clears the board,
// drops MINES mines at LFSR-chosen cells, then fills every free cell with its
// neighbour-mine count, one cell per clock.
module board_generator #(
    parameter int          MINES = 30,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic         clk_pix,
    input  logic         sim_rst_n,
    board_generator_if.slave bus
);

    localparam int         CELLS    = 225;
    localparam logic [3:0] MINE     = 4'd10;
    localparam logic [7:0] LAST_K   = 8'd224;
    localparam logic [7:0] MINES_M1 = 8'(MINES - 1);

    // Reject an out-of-range mine count while the design is elaborated.
    if (MINES < 1 || MINES > 200) begin : g_bad_mines
        $error("board_generator: MINES=%0d outside 1..200", MINES);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLACE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [3:0]  board [0:CELLS-1];
    logic [7:0]  mines_cnt;
    logic [7:0]  k;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        busy_q;
    logic        done_q;

    logic [CELLS-1:0] is_mine;
    logic [7:0]       cand;
    logic             cand_ok;
    logic [3:0]       nbr_sum;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign bus.data_minesweeper = board;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.mines_placed     = mines_cnt;

    // Free-running LFSR; a seeded start replaces one step with the seed.
    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            lfsr <= SEED;
        end else if (bus.start && bus.seed_load) begin
            lfsr <= (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Mine marker per cell, used by both candidate rejection and counting.
    always_comb begin
        is_mine = '0;
        for (int i = 0; i < CELLS; i++) begin
            is_mine[i] = (board[i] == MINE);
        end
    end

    // Placement candidate: low byte of the LFSR, accepted if on-board and free.
    always_comb begin
        cand    = lfsr[7:0];
        cand_ok = (cand < 8'(CELLS)) && !is_mine[cand];
    end

    // Neighbour-mine count for cell k; edge flags stop wrap-around reads.
    always_comb begin
        logic has_l, has_r, has_u, has_d;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nbr_sum = '0;
        has_l   = (x != 4'd0);
        has_r   = (x != 4'd14);
        has_u   = (y != 4'd0);
        has_d   = (y != 4'd14);
        nbr_sum = {3'b000, has_u && has_l && is_mine[k - 8'd16]}
                + {3'b000, has_u          && is_mine[k - 8'd15]}
                + {3'b000, has_u && has_r && is_mine[k - 8'd14]}
                + {3'b000, has_l          && is_mine[k - 8'd1]}
                + {3'b000, has_r          && is_mine[k + 8'd1]}
                + {3'b000, has_d && has_l && is_mine[k + 8'd14]}
                + {3'b000, has_d          && is_mine[k + 8'd15]}
                + {3'b000, has_d && has_r && is_mine[k + 8'd16]};
    end

    // State register.
    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start in any state (re)starts from CLEAR.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  state_next = S_IDLE;
            S_CLEAR: state_next = S_PLACE;
            S_PLACE: if (cand_ok && mines_cnt == MINES_M1) state_next = S_COUNT;
            S_COUNT: if (k == LAST_K) state_next = S_COUNT == state ? S_DONE : S_COUNT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.start) begin
            state_next = S_CLEAR;
        end
    end

    // Board, counters and registered status flags.
    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            // NOTE: the board is a register array that must read all-zero out of reset, so it is reset explicitly.
            for (int i = 0; i < CELLS; i++) begin
                board[i] <= '0;
            end
            mines_cnt <= '0;
            k         <= '0;
            x         <= '0;
            y         <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= (state_next != S_IDLE);
            done_q <= (state_next == S_DONE);
            unique case (state)
                S_CLEAR: begin
                    for (int i = 0; i < CELLS; i++) begin
                        board[i] <= '0;
                    end
                    mines_cnt <= '0;
                    k         <= '0;
                    x         <= '0;
                    y         <= '0;
                end
                S_PLACE: begin
                    if (cand_ok) begin
                        board[cand] <= MINE;
                        mines_cnt   <= mines_cnt + 8'd1;
                    end
                end
                S_COUNT: begin
                    if (!is_mine[k]) begin
                        board[k] <= nbr_sum;
                    end
                    k <= k + 8'd1;
                    if (x == 4'd14) begin
                        x <= 4'd0;
                        y <= y + 4'd1;
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator: directed scenario sequence with
// random seeds and gaps, checked against a cell-level board model.
module tb_board_generator;

    localparam int          MINES = 30;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          CELLS = 225;

    logic clk_pix   = 1'b0;
    logic sim_rst_n = 1'b0;

    always #5 clk_pix = ~clk_pix;

    board_generator_if bus ();

    board_generator #(.MINES(MINES), .SEED(SEED)) dut (
        .clk_pix   (clk_pix),
        .sim_rst_n (sim_rst_n),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_board [0:CELLS-1];
    int         exp_place;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] load_val(input logic [15:0] s);
        return (s == 16'h0000) ? SEED : s;
    endfunction

    // Model: v0 is the LFSR value in the CLEAR cycle; PLACE draws from the
    // following values. Produces the final board and the PLACE length.
    function automatic void build_model(input logic [15:0] v0);
        bit          mine [0:CELLS-1];
        int          placed;
        logic [15:0] v;
        placed    = 0;
        exp_place = 0;
        v         = step(v0);
        for (int i = 0; i < CELLS; i++) mine[i] = 1'b0;
        while (placed < MINES) begin
            int c;
            c = int'(v[7:0]);
            exp_place++;
            if (c < CELLS && !mine[c]) begin
                mine[c] = 1'b1;
                placed++;
            end
            v = step(v);
        end
        for (int yy = 0; yy < 15; yy++) begin
            for (int xx = 0; xx < 15; xx++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if ((dx != 0 || dy != 0) && xx + dx >= 0 && xx + dx <= 14 &&
                            yy + dy >= 0 && yy + dy <= 14 && mine[(yy + dy) * 15 + xx + dx])
                            n++;
                    end
                end
                exp_board[yy * 15 + xx] = mine[yy * 15 + xx] ? 4'd10 : 4'(n);
            end
        end
    endfunction

    // Drive a start on the falling edge; returns 1ns after the sampling edge.
    task automatic issue_start(input logic [15:0] s, input logic ld);
        @(negedge clk_pix);
        bus.start     = 1'b1;
        bus.seed_load = ld;
        bus.seed_in   = s;
        @(posedge clk_pix);
        #1;
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
    endtask

    // Edges after the start edge until done is seen (bounded); busy must hold.
    task automatic wait_done(input string tag, output int n);
        bit found;
        bit busy_ok;
        found   = 1'b0;
        busy_ok = 1'b1;
        n       = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk_pix);
            #1;
            n++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) found = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic check_board(input string tag);
        int mines;
        mines = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (bus.data_minesweeper[i] === 4'd10) mines++;
            check($sformatf("%s_cell%0d", tag, i), {28'b0, bus.data_minesweeper[i]}, {28'b0, exp_board[i]});
        end
        check({tag, "_mine_total"}, 32'(mines), 32'(MINES));
        check({tag, "_mines_placed"}, {24'b0, bus.mines_placed}, 32'(MINES));
    endtask

    // Latency in cycles from the start cycle to the done cycle is n+1.
    task automatic check_run(input string tag, input int n);
        check({tag, "_latency"}, 32'(n + 1), 32'(exp_place + 227));
        check({tag, "_latency_min"}, 32'(n + 1 >= MINES + 227), 32'd1);
        check_board(tag);
    endtask

    task automatic after_done(input string tag);
        @(posedge clk_pix);
        #1;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_fell"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        int nonzero;
        nonzero = 0;
        for (int i = 0; i < CELLS; i++) if (bus.data_minesweeper[i] !== 4'd0) nonzero++;
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_mines_placed"}, {24'b0, bus.mines_placed}, 32'd0);
        check({tag, "_board_nonzero"}, 32'(nonzero), 32'd0);
    endtask

    initial begin
        int          n;
        int          lat_a;
        int          idle_n;
        int          dones;
        logic [15:0] s;
        logic [15:0] v0;

        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0000;

        // Reset and idle.
        #23;
        check_reset_state("in_reset");
        @(negedge clk_pix);
        sim_rst_n = 1'b1;
        repeat (10) @(posedge clk_pix);
        #1;
        check_reset_state("idle10");

        // Seeded run with 16'h1234.
        issue_start(16'h1234, 1'b1);
        build_model(16'h1234);
        wait_done("seed1234", n);
        check_run("seed1234", n);
        lat_a = n;
        after_done("seed1234");

        // Same seed again, then a third time started in the DONE cycle.
        issue_start(16'h1234, 1'b1);
        wait_done("repeat1", n);
        check("repeat1_same_latency", 32'(n), 32'(lat_a));
        check_run("repeat1", n);
        issue_start(16'h1234, 1'b1);
        check("done_cycle_start_busy", 32'(bus.busy), 32'd1);
        check("done_cycle_start_done", 32'(bus.done), 32'd0);
        wait_done("repeat2", n);
        check("repeat2_same_latency", 32'(n), 32'(lat_a));
        check_run("repeat2", n);
        after_done("repeat2");

        // Zero seed substitutes SEED.
        issue_start(16'h0000, 1'b1);
        build_model(SEED);
        wait_done("zero_seed", n);
        check_run("zero_seed", n);
        after_done("zero_seed");

        // Random seeds with random idle gaps.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk_pix);
            s = 16'($urandom);
            issue_start(s, 1'b1);
            build_model(load_val(s));
            wait_done($sformatf("rand%0d", r), n);
            check_run($sformatf("rand%0d", r), n);
            after_done($sformatf("rand%0d", r));
        end

        // Abort at COUNT cycle 100, then a clean second run.
        s = 16'($urandom);
        issue_start(s, 1'b1);
        build_model(load_val(s));
        dones = 0;
        for (int i = 0; i < exp_place + 100; i++) begin
            @(posedge clk_pix);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        s = 16'($urandom);
        issue_start(s, 1'b1);
        if (bus.done === 1'b1) dones++;
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_clear_busy", 32'(bus.busy), 32'd1);
        build_model(load_val(s));
        wait_done("after_abort", n);
        check_run("after_abort", n);
        after_done("after_abort");
        dones = 0;
        repeat (20) begin
            @(posedge clk_pix);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("after_abort_no_extra_done", 32'(dones), 32'd0);

        // Asynchronous reset during PLACE.
        issue_start(16'hBEEF, 1'b1);
        repeat (5) @(posedge clk_pix);
        #2;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        sim_rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk_pix);
        sim_rst_n = 1'b1;
        idle_n = $urandom_range(5, 20);
        dones  = 0;
        repeat (idle_n) begin
            @(posedge clk_pix);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) dones++;
        end
        check("post_reset_stays_idle", 32'(dones), 32'd0);
        check_reset_state("post_reset_idle");

        // Unseeded start: LFSR has free-run from SEED since reset release.
        v0 = SEED;
        for (int i = 0; i < idle_n + 1; i++) v0 = step(v0);
        issue_start(16'hFFFF, 1'b0);
        build_model(v0);
        wait_done("free_run", n);
        check_run("free_run", n);
        after_done("free_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
